// File: rtl/dnu_f0_lut_loader_if.sv
// Stream-in / RAM-write-port bundle for the DNU f0 LUT loader.
// The loader side uses the master modport; source and RAM model use slave.
interface dnu_f0_lut_loader_if #(
    parameter int ENTRY_ADDR = 7,
    parameter int WORD_W     = 2
);
    logic                  lut_in_valid;
    logic [WORD_W-1:0]     lut_in_data;
    logic                  lut_in_ready;
    logic [ENTRY_ADDR-1:0] page_addr_ram;
    logic [WORD_W-1:0]     ram_write_data_1;
    logic                  ib_ram_we;

    modport master (
        input  lut_in_valid,
        input  lut_in_data,
        output lut_in_ready,
        output page_addr_ram,
        output ram_write_data_1,
        output ib_ram_we
    );

    modport slave (
        output lut_in_valid,
        output lut_in_data,
        input  lut_in_ready,
        input  page_addr_ram,
        input  ram_write_data_1,
        input  ib_ram_we
    );
endinterface

// File: rtl/dnu_f0_lut_loader.sv
// Write-side sequencer for the IB-DNU f0 symmetric LUT RAM: turns a valid/ready
// stream of packed two-bank words into page-addressed RAM writes for one frame or all pages.
module dnu_f0_lut_loader #(
    parameter int ENTRY_ADDR      = 7,
    parameter int BANK_NUM        = 2,
    parameter int LUT_PORT_SIZE   = 1,
    parameter int MULTI_FRAME_NUM = 2
) (
    input  logic                     write_clk,
    input  logic                     rstn,
    input  logic                     load_start,
    input  logic                     load_full,
    input  logic                     load_frame,
    input  logic                     load_abort,
    dnu_f0_lut_loader_if.master      lut_bus,
    output logic                     busy,
    output logic                     load_done
);
    localparam int WORD_W      = LUT_PORT_SIZE * BANK_NUM;
    localparam int PAGES_TOTAL = 1 << ENTRY_ADDR;
    localparam int PAGES_FRAME = PAGES_TOTAL / MULTI_FRAME_NUM;

    localparam logic [ENTRY_ADDR-1:0] LAST_FULL  = ENTRY_ADDR'(PAGES_TOTAL - 1);
    localparam logic [ENTRY_ADDR-1:0] LAST_FRAME = ENTRY_ADDR'(PAGES_FRAME - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  full_q, full_d;
    logic [ENTRY_ADDR-1:0] base_q, base_d;
    logic [ENTRY_ADDR-1:0] cnt_q, cnt_d;
    logic [ENTRY_ADDR-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  in_load;
    logic                  beat;
    logic [ENTRY_ADDR-1:0] last_cnt;

    assign in_load  = (state_q == ST_LOAD);
    assign beat     = lut_bus.lut_in_valid & in_load;
    assign last_cnt = full_q ? LAST_FULL : LAST_FRAME;

    always_comb begin
        // NOTE: every next-state signal starts from a default so no path through the case infers a latch.
        state_d = state_q;
        full_d  = full_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Abort is meaningless here, so a coincident start always wins.
                if (load_start) begin
                    full_d  = load_full;
                    base_d  = load_full ? '0 : {load_frame, {(ENTRY_ADDR-1){1'b0}}};
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    state_d = ST_IDLE;
                end else if (beat) begin
                    we_d    = 1'b1;
                    addr_d  = base_q + cnt_q;
                    wdata_d = lut_bus.lut_in_data;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == last_cnt) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Write data is reset along with the address so the RAM port shows a known word after reset.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            full_q  <= 1'b0;
            base_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            full_q  <= full_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign lut_bus.lut_in_ready     = in_load;
    assign lut_bus.page_addr_ram    = addr_q;
    assign lut_bus.ram_write_data_1 = wdata_q;
    assign lut_bus.ib_ram_we        = we_q;
    assign busy                     = busy_q;
    assign load_done                = done_q;
endmodule

// File: tb/tb_dnu_f0_lut_loader.sv
// Directed bench for dnu_f0_lut_loader: expected writes are queued as beats are
// driven and popped by a negedge monitor whenever the RAM write enable fires.
module tb_dnu_f0_lut_loader;
    logic write_clk = 1'b0;
    logic rstn;
    logic load_start, load_full, load_frame, load_abort;
    logic busy, load_done;

    dnu_f0_lut_loader_if #(.ENTRY_ADDR(7), .WORD_W(2)) bus ();

    dnu_f0_lut_loader #(
        .ENTRY_ADDR(7), .BANK_NUM(2), .LUT_PORT_SIZE(1), .MULTI_FRAME_NUM(2)
    ) dut (
        .write_clk (write_clk),
        .rstn      (rstn),
        .load_start(load_start),
        .load_full (load_full),
        .load_frame(load_frame),
        .load_abort(load_abort),
        .lut_bus   (bus.master),
        .busy      (busy),
        .load_done (load_done)
    );

    always #5 write_clk = ~write_clk;

    typedef struct {
        logic [6:0] addr;
        logic [1:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic [6:0] hold_addr = '0;
    logic [1:0] hold_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: each write must match the oldest outstanding beat.
    always @(negedge write_clk) begin
        if (!rstn) begin
            hold_addr = '0;
            hold_data = '0;
        end else if (bus.ib_ram_we) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("write_without_beat", 32'(bus.ib_ram_we), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(bus.page_addr_ram), 32'(e.addr));
                check("wr_data", 32'(bus.ram_write_data_1), 32'(e.data));
                check("done_on_write", 32'(load_done), 32'(e.last));
                hold_addr = e.addr;
                hold_data = e.data;
            end
        end else begin
            check("addr_hold", 32'(bus.page_addr_ram), 32'(hold_addr));
            check("data_hold", 32'(bus.ram_write_data_1), 32'(hold_data));
            check("done_without_write", 32'(load_done), 32'd0);
        end
        if (rstn && load_done) done_cnt++;
    end

    task automatic step();
        @(posedge write_clk);
        #1;
    endtask

    task automatic start_load(input logic full, input logic frame, input logic abort);
        load_start = 1'b1;
        load_full  = full;
        load_frame = frame;
        load_abort = abort;
        step();
        load_start = 1'b0;
        load_abort = 1'b0;
    endtask

    task automatic beat(input logic [1:0] data, input logic [6:0] base, input int k,
                        input logic last, input logic push);
        exp_t e;
        bus.lut_in_valid = 1'b1;
        bus.lut_in_data  = data;
        check("ready_in_load", 32'(bus.lut_in_ready), 32'd1);
        if (push) begin
            e.addr = base + 7'(k);
            e.data = data;
            e.last = last;
            sb.push_back(e);
        end
        step();
        bus.lut_in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(bus.page_addr_ram), 32'd0);
        check({tag, "_data"}, 32'(bus.ram_write_data_1), 32'd0);
        check({tag, "_we"}, 32'(bus.ib_ram_we), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_ready"}, 32'(bus.lut_in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Checks the two-cycle tail after the final beat and the per-load totals.
    task automatic finish_load(input int w0, input int d0, input int n_writes);
        check("busy_in_done", 32'(busy), 32'd1);
        check("ready_in_done", 32'(bus.lut_in_ready), 32'd0);
        step();
        check("busy_after_done", 32'(busy), 32'd0);
        check("load_writes", 32'(wr_cnt - w0), 32'(n_writes));
        check("load_done_count", 32'(done_cnt - d0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int w0, d0;
        rstn             = 1'b1;
        load_start       = 1'b0;
        load_full        = 1'b0;
        load_frame       = 1'b0;
        load_abort       = 1'b0;
        bus.lut_in_valid = 1'b0;
        bus.lut_in_data  = '0;
        #1 rstn = 1'b0;
        #2 check_reset_outputs("reset");
        step();
        rstn = 1'b1;

        // Valid in IDLE must not write or raise ready.
        bus.lut_in_valid = 1'b1;
        bus.lut_in_data  = 2'b11;
        for (int i = 0; i < 10; i++) begin
            check("idle_ready", 32'(bus.lut_in_ready), 32'd0);
            check("idle_we", 32'(bus.ib_ram_we), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            step();
        end
        bus.lut_in_valid = 1'b0;

        // Half load, frame 1, continuous valid.
        w0 = wr_cnt; d0 = done_cnt;
        start_load(1'b0, 1'b1, 1'b0);
        check("busy_in_load", 32'(busy), 32'd1);
        for (int k = 0; k < 64; k++) beat(2'(k % 4), 7'd64, k, k == 63, 1'b1);
        finish_load(w0, d0, 64);

        // Full load with alternating bubbles.
        w0 = wr_cnt; d0 = done_cnt;
        start_load(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 128; k++) begin
            beat(2'($urandom_range(0, 3)), 7'd0, k, k == 127, 1'b1);
            if (k == 64) check("msb_after_half", 32'(bus.page_addr_ram[6]), 32'd1);
            if (k != 127) step();
        end
        finish_load(w0, d0, 128);

        // Abort on beat 10: that beat is dropped and no completion is reported.
        w0 = wr_cnt; d0 = done_cnt;
        start_load(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) beat(2'(k % 4), 7'd0, k, 1'b0, 1'b1);
        load_abort = 1'b1;
        beat(2'b10, 7'd0, 10, 1'b0, 1'b0);
        load_abort = 1'b0;
        check("abort_ready", 32'(bus.lut_in_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        step();
        check("abort_writes", 32'(wr_cnt - w0), 32'd10);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        // Restart at base 0, with abort held alongside start (start wins).
        w0 = wr_cnt; d0 = done_cnt;
        start_load(1'b0, 1'b0, 1'b1);
        check("start_beats_abort", 32'(bus.lut_in_ready), 32'd1);
        for (int k = 0; k < 64; k++) beat(2'(3 - k % 4), 7'd0, k, k == 63, 1'b1);
        finish_load(w0, d0, 64);

        // A second start during a frame-1 load must not re-latch the mode.
        w0 = wr_cnt; d0 = done_cnt;
        start_load(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 64; k++) begin
            if (k == 32) begin
                load_start = 1'b1;
                load_full  = 1'b1;
                load_frame = 1'b0;
            end
            beat(2'(k % 3), 7'd64, k, k == 63, 1'b1);
            load_start = 1'b0;
        end
        finish_load(w0, d0, 64);

        // Asynchronous reset after 20 beats, then a clean reload from base.
        w0 = wr_cnt; d0 = done_cnt;
        start_load(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) beat(2'(k % 4), 7'd64, k, 1'b0, 1'b1);
        @(negedge write_clk);
        #1 rstn = 1'b0;
        #1 check_reset_outputs("midload_reset");
        check("reset_writes", 32'(wr_cnt - w0), 32'd20);
        check("reset_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge write_clk);
        step();
        rstn = 1'b1;
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);
        step();
        check("post_reset_idle_we", 32'(bus.ib_ram_we), 32'd0);
        w0 = wr_cnt; d0 = done_cnt;
        start_load(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 64; k++) beat(2'(k % 4), 7'd64, k, k == 63, 1'b1);
        finish_load(w0, d0, 64);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dnu_f0_lut_loader.md
Name: dnu_f0_lut_loader

Overview:
- Write-side sequencer for the IB-DNU f0 symmetric LUT RAM during iteration updates.
- Accepts a valid/ready stream of packed two-bank LUT words from the iteration-update source.
- Generates the page write address, the frame offset bit, the packed write data and the RAM write enable, in the format the DNU f0 sub-datapath consumes on its write port.
- Loads either one multi-frame half or the full page space.

Parameters:
- ENTRY_ADDR, 7, page address width; MSB is the multi-frame write offset, the lower ENTRY_ADDR-1 bits are the page write address.
- BANK_NUM, 2, number of LUT banks packed per word.
- LUT_PORT_SIZE, 1, bits per bank per page.
- MULTI_FRAME_NUM, 2, number of frames; the half size is 2^(ENTRY_ADDR-1) pages.

Ports:
- write_clk  input  1  sole clock; all logic is on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle request to begin a load; sampled in IDLE only.
- load_full  input  1  sampled with load_start; 1 = all 2^ENTRY_ADDR pages, 0 = one frame half.
- load_frame  input  1  sampled with load_start when load_full=0; frame offset (page_addr_ram MSB) to load.
- load_abort  input  1  synchronous abort of a load in progress.
- lut_in_valid  input  1  source word valid.
- lut_in_data  input  LUT_PORT_SIZE*BANK_NUM  packed word; upper LUT_PORT_SIZE bits = bank0, lower = bank1.
- lut_in_ready  output  1  loader can accept a word.
- page_addr_ram  output  ENTRY_ADDR  RAM page address; MSB = write offset.
- ram_write_data_1  output  LUT_PORT_SIZE*BANK_NUM  RAM write data, same packing as lut_in_data.
- ib_ram_we  output  1  RAM write enable.
- busy  output  1  high in LOAD and DONE.
- load_done  output  1  one-cycle pulse on completion.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; page_addr_ram=0, ram_write_data_1=0, ib_ram_we=0, load_done=0, page counter=0, lut_in_ready=0.
- States:
  - IDLE: load_start=1 latches the mode. Base address = 0 if load_full, else {load_frame, zeros}. Page count N = 2^ENTRY_ADDR if load_full, else 2^(ENTRY_ADDR-1). Clear the counter, go to LOAD.
  - LOAD: lut_in_ready=1 (decoded combinationally from state). A beat is lut_in_valid & lut_in_ready.
    - Beat number k at cycle t: at t+1, ib_ram_we=1, page_addr_ram=base+k, ram_write_data_1 = the beat's data.
    - No beat in a cycle: ib_ram_we=0 next cycle; page_addr_ram and ram_write_data_1 hold their values.
    - Beat k=N-1: go to DONE.
  - DONE: lut_in_ready=0. Lasts exactly one cycle, then IDLE.
- Output timing:
  - All outputs except lut_in_ready are registered.
  - load_done=1 in the same cycle as the final ib_ram_we, i.e. the cycle after the last beat.
- Address arithmetic: unsigned addition of base + counter with no wrap beyond N.
  - load_full=0: the MSB stays at load_frame for the whole load.
  - load_full=1: address runs 0..2^ENTRY_ADDR-1 and the MSB toggles at the half boundary.
- Ignored inputs:
  - load_start in LOAD or DONE is ignored; the mode is not re-latched.
  - lut_in_valid in IDLE or DONE causes no write.
- load_abort:
  - In LOAD: next state IDLE. ib_ram_we=0 from the next cycle. A beat presented in the same cycle as the abort is discarded. load_done is not pulsed.
  - In DONE: ignored, so completion still reports.
  - In IDLE: ignored.
  - load_abort together with load_start in IDLE: the start wins (abort has no effect in IDLE).
- Back-to-back loads: load_start in the IDLE cycle directly after DONE is accepted, so there is a minimum 1-cycle gap between loads with ready low.
- Reset mid-load: immediate return to reset values. No partial state persists; the next load restarts at its base.

Test Plan:
- Reset then idle: with rstn asserted, all outputs 0. lut_in_valid=1 in IDLE for 10 cycles -> ib_ram_we stays 0, lut_in_ready=0.
- Half load, frame 1: load_start with load_full=0, load_frame=1, and continuous valid with data = k mod 4 -> 64 writes at page_addr_ram 64..127, one per cycle, data matching, load_done coincident with the write to 127, busy drops 2 cycles after the last beat.
- Full load with bubbles: load_full=1, valid toggling 1,0,1,0 -> exactly 128 writes at addresses 0..127 in order, with no write in bubble cycles and the address held between writes. The address MSB goes 0->1 after address 63.
- Abort: load_full=0, load_frame=0, abort asserted on beat 10 with valid=1 -> writes to addresses 0..9 only, no write for beat 10, no load_done, IDLE the next cycle. A new half load with load_frame=0 then starts at address 0.
- Start while busy: a second load_start with load_frame=0 during a frame-1 half load -> ignored, all addresses stay in 64..127, exactly one load_done.
- Async reset mid-load: rstn low for 1 cycle after 20 beats -> outputs 0 immediately with no further writes. Re-start completes all 64 writes from base.
